// File: rtl/spi_seq.sv
//------------------------------------------------------------------------------
// Module   : spi_seq
// Brief    : Multi-byte SPI transaction sequencer placed in front of a
//            single-byte SPI master. Frames a whole transfer with chip
//            select, feeds the master from a TX FIFO one byte per wr pulse
//            and collects the received bytes into an RX FIFO.
// Options  : SPI_SEQ_RX_EN - when defined, the RX FIFO, rx_ovf and rx_rd
//            logic are built. When undefined the block is write-only:
//            rx_empty=1, rx_data=0, rx_ovf=0 and m_dout is discarded.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_seq #(
  parameter int         DEPTH = 8,      // FIFO depth in bytes, power of two 2..256
  parameter logic [7:0] FILL  = 8'hFF   // byte sent when TX runs dry mid-transfer
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active low
  // host TX side
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  // host RX side
  output logic [7:0] rx_data,
  input  logic       rx_rd,
  output logic       rx_empty,
  // transfer control
  input  logic       start,
  input  logic [7:0] xfer_len,
  input  logic [7:0] cfg_dvsr,
  output logic       busy,
  output logic       xfer_done,
  output logic       rx_ovf,
  // SPI chip select
  output logic       spi_cs_n,
  // byte master interface
  output logic [7:0] m_din,
  output logic [7:0] m_dvsr,
  output logic       m_wr,
  input  logic [7:0] m_dout,
  input  logic       m_done,
  input  logic       m_idle
);

  localparam int             c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_ptr_one = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // FSM state and sequencing registers
  state_t     r_state;
  state_t     w_state_nx;
  logic       r_cnt;          // two-cycle phase counter for SETUP and HOLD
  logic       w_cnt_nx;
  logic [7:0] r_remaining;    // bytes still to be exchanged in this frame

  // FSM decode strobes
  logic       w_accept;       // start accepted in IDLE
  logic       w_try_load;     // FSM wants to hand a byte to the master
  logic       w_issue;        // byte handed to the master this cycle
  logic       w_rx_capture;   // master returned a byte while in WAIT
  logic       w_finish;       // last HOLD cycle, frame ends

  // registered outputs
  logic       r_busy;
  logic       r_cs_n;
  logic       r_done;
  logic       r_m_wr;
  logic [7:0] r_m_din;
  logic [7:0] r_m_dvsr;

  //----------------------------------------------------------------------------
  // TX FIFO
  //----------------------------------------------------------------------------
  logic [7:0]  r_tx_mem [DEPTH];
  logic [c_aw:0] r_tx_wp;
  logic [c_aw:0] r_tx_rp;
  logic        w_tx_empty;
  logic        w_tx_full;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic [7:0]  w_tx_head;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[c_aw-1:0] == r_tx_rp[c_aw-1:0]) &&
                      (r_tx_wp[c_aw] != r_tx_rp[c_aw]);
  assign w_tx_head  = r_tx_mem[r_tx_rp[c_aw-1:0]];
  // A pop never happens on an empty FIFO; FILL is sent instead.
  assign w_tx_pop   = w_issue && !w_tx_empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_tx_push  = tx_wr && (!w_tx_full || w_tx_pop);

  // TX storage write port; contents need no reset because pointers gate them
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wp[c_aw-1:0]] <= tx_data;
    end
  end

  // TX pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wp <= r_tx_wp + c_ptr_one;
      end
      if (w_tx_pop) begin
        r_tx_rp <= r_tx_rp + c_ptr_one;
      end
    end
  end

  assign tx_full = w_tx_full;

  //----------------------------------------------------------------------------
  // RX FIFO (optional)
  //----------------------------------------------------------------------------
`ifdef SPI_SEQ_RX_EN
  logic [7:0]    r_rx_mem [DEPTH];
  logic [c_aw:0] r_rx_wp;
  logic [c_aw:0] r_rx_rp;
  logic          w_rx_empty;
  logic          w_rx_full;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          r_rx_ovf;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[c_aw-1:0] == r_rx_rp[c_aw-1:0]) &&
                      (r_rx_wp[c_aw] != r_rx_rp[c_aw]);
  assign w_rx_pop   = rx_rd && !w_rx_empty;
  assign w_rx_push  = w_rx_capture && (!w_rx_full || w_rx_pop);

  // RX storage write port
  always_ff @(posedge clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wp[c_aw-1:0]] <= m_dout;
    end
  end

  // RX pointers and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_rx_push) begin
        r_rx_wp <= r_rx_wp + c_ptr_one;
      end
      if (w_rx_pop) begin
        r_rx_rp <= r_rx_rp + c_ptr_one;
      end
      if (w_accept) begin
        r_rx_ovf <= 1'b0;
      end else if (w_rx_capture && !w_rx_push) begin
        r_rx_ovf <= 1'b1;
      end
    end
  end

  // Head is masked to zero while empty so stale storage never shows.
  assign rx_data  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[c_aw-1:0]];
  assign rx_empty = w_rx_empty;
  assign rx_ovf   = r_rx_ovf;
`else
  // Write-only build: received bytes and host reads are discarded.
  logic w_unused;
  assign w_unused = &{1'b0, rx_rd, m_dout, w_rx_capture};

  assign rx_data  = 8'h00;
  assign rx_empty = 1'b1;
  assign rx_ovf   = 1'b0;
`endif

  //----------------------------------------------------------------------------
  // Sequencer FSM
  //----------------------------------------------------------------------------

  // FSM state register, phase counter and byte countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 1'b0;
      r_remaining <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_remaining <= xfer_len;
      end else if (w_rx_capture) begin
        r_remaining <= r_remaining - 8'd1;
      end
    end
  end

  // Next-state decode; a load request issues immediately when the master is
  // idle, so the first byte and back-to-back bytes lose no extra cycle.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_accept     = 1'b0;
    w_try_load   = 1'b0;
    w_issue      = 1'b0;
    w_rx_capture = 1'b0;
    w_finish     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && (xfer_len != 8'd0)) begin
          w_accept   = 1'b1;
          w_state_nx = S_SETUP;
          w_cnt_nx   = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_cnt) begin
          w_try_load = 1'b1;
        end else begin
          w_cnt_nx = 1'b1;
        end
      end
      S_LOAD: begin
        w_try_load = 1'b1;
      end
      S_WAIT: begin
        if (m_done) begin
          w_rx_capture = 1'b1;
          if (r_remaining == 8'd1) begin
            w_state_nx = S_HOLD;
            w_cnt_nx   = 1'b0;
          end else begin
            w_try_load = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (r_cnt) begin
          w_finish   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_try_load) begin
      if (m_idle) begin
        w_issue    = 1'b1;
        w_state_nx = S_WAIT;
      end else begin
        w_state_nx = S_LOAD;
      end
    end
  end

  // Registered outputs to the host, the chip select and the byte master
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_done   <= 1'b0;
      r_m_wr   <= 1'b0;
      r_m_din  <= 8'h00;
      r_m_dvsr <= 8'h00;
    end else begin
      r_done <= w_finish;
      r_m_wr <= w_issue;
      if (w_accept) begin
        r_busy   <= 1'b1;
        r_cs_n   <= 1'b0;
        r_m_dvsr <= cfg_dvsr;
      end else if (w_finish) begin
        r_busy <= 1'b0;
        r_cs_n <= 1'b1;
      end
      if (w_issue) begin
        r_m_din <= w_tx_empty ? FILL : w_tx_head;
      end
    end
  end

  assign busy      = r_busy;
  assign spi_cs_n  = r_cs_n;
  assign xfer_done = r_done;
  assign m_wr      = r_m_wr;
  assign m_din     = r_m_din;
  assign m_dvsr    = r_m_dvsr;

endmodule

`default_nettype wire

// File: doc/spi_seq.md
# spi_seq

Multi-byte transaction sequencer that sits directly upstream of the `spi` byte master. Host logic preloads bytes into a TX FIFO and issues a length-tagged start. The block asserts chip-select, feeds the master one byte per `wr` pulse, collects each received byte into an RX FIFO, and releases chip-select after the last byte. It turns the master's single-byte handshake into whole framed transfers.

## Interface
- `DEPTH`, 8: TX and RX FIFO depth in bytes; power of two, 2..256
- `FILL`, 8'hFF: byte sent when the TX FIFO is empty mid-transfer
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `tx_data`  in  8  byte to enqueue
- `tx_wr`  in  1  enqueue strobe; ignored when `tx_full`
- `tx_full`  out  1  TX FIFO holds DEPTH bytes
- `rx_data`  out  8  head of RX FIFO; valid while `rx_empty`=0
- `rx_rd`  in  1  dequeue strobe; ignored when `rx_empty`
- `rx_empty`  out  1  RX FIFO empty
- `start`  in  1  begin transfer; sampled only in IDLE
- `xfer_len`  in  8  byte count, sampled with `start`; 0 = no-op
- `cfg_dvsr`  in  8  SCLK divisor, forwarded to master, latched at `start`
- `busy`  out  1  high from accepted `start` until return to IDLE
- `xfer_done`  out  1  one-cycle pulse on return to IDLE after a transfer
- `rx_ovf`  out  1  sticky: a received byte was dropped because RX FIFO full; cleared on accepted `start`
- `spi_cs_n`  out  1  chip select, active low
- `m_din`, `m_dvsr`  out  8  to master `din`/`dvsr`
- `m_wr`  out  1  one-cycle start pulse to master
- `m_dout`  in  8  master received byte, valid when `m_done`=1
- `m_done`, `m_idle`  in  1  master byte-complete pulse / idle level

## Operation
- FSM states: IDLE, SETUP, LOAD, WAIT, HOLD.
- IDLE: on `start`=1 with `xfer_len`≠0, latch `xfer_len` into `remaining`, latch `cfg_dvsr`, clear `rx_ovf`, go to SETUP. `start` with `xfer_len`=0 is ignored and produces no `xfer_done`.
- SETUP: `spi_cs_n`=0; 2 cycles, then LOAD.
- LOAD: wait for `m_idle`=1. Then pulse `m_wr` and drive `m_din` = TX head (popped this cycle), or `FILL` if TX is empty (no pop). Go to WAIT.
- WAIT: on `m_done`, push `m_dout` to RX (drop and set `rx_ovf` if full) and decrement `remaining`. Next state is LOAD if `remaining`≠0 after the decrement, else HOLD.
- HOLD: `spi_cs_n`=0 for 2 cycles, then deassert, pulse `xfer_done`, go to IDLE.
- `start` outside IDLE is ignored.
- Host `tx_wr` is allowed while busy, so host may stream bytes into the FIFO.
- FIFOs: binary pointers with an extra wrap bit. Full = addresses equal and wrap bits differ. Simultaneous push+pop when full: pop takes effect and push is accepted. Simultaneous push+pop when empty: push only.
- `m_dvsr` holds the latched divisor continuously.

## Timing
- Reset (rst=0, async): state IDLE, FIFOs empty, `spi_cs_n`=1, `m_wr`=0, `m_din`=0, `m_dvsr`=0, `busy`=0, `xfer_done`=0, `rx_ovf`=0, `tx_full`=0, `rx_empty`=1, `rx_data`=0.
- Reset mid-transfer: CS releases immediately and all FIFO contents are lost.
- Cycle N `start` accepted:
  - `busy`, `spi_cs_n`=0 at N+1.
  - First `m_wr` at N+3 if `m_idle`=1.
- Byte boundary: `m_done` at cycle M → RX write visible (`rx_empty`=0) at M+1 → next `m_wr` at M+1 earliest.
- Last `m_done` at M → `spi_cs_n`=1 and `xfer_done`=1 at M+3 → `busy`=0 at M+3.
- All outputs are registered.
- `m_done` arriving outside WAIT is ignored.

## Configuration
- `SPI_SEQ_RX_EN` defined: RX FIFO, `rx_ovf` and `rx_rd` logic are present as above.
- Not defined: no RX storage. `rx_empty`=1, `rx_data`=0 and `rx_ovf`=0 constantly, and `m_dout` is discarded. The block becomes a write-only sequencer.

## Test plan
- Reset with `tx_wr` high → all outputs at reset values; after release, 8 writes set `tx_full`=1 and a 9th write is dropped.
- Load 0xA5,0x3C; `start` with `xfer_len`=2, `cfg_dvsr`=7; loopback MOSI→MISO → master sees `din` 0xA5 then 0x3C; RX returns 0xA5,0x3C; one `xfer_done`; CS low throughout.
- Empty TX, `xfer_len`=3 → three `m_wr` with `m_din`=0xFF; 3 RX entries.
- RX pre-filled to 7, `xfer_len`=3 → 1 byte stored, 2 dropped, `rx_ovf`=1; next `start` clears it.
- Assert `rst`=0 during second byte of 4 → `spi_cs_n`=1 same cycle; FIFOs empty; later `start` runs normally.
- `start` while busy and `start` with `xfer_len`=0 → no effect, no extra `xfer_done`.
